// File: rtl/cpu_test_port_if.sv
// rtl/cpu_test_port_if.sv - CPU data-bus request/response bundle for the test port
interface cpu_test_port_if #(
  parameter int CPU_WIDTH = 32
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [3:0]           req_addr;
  logic [CPU_WIDTH-1:0] req_wdata;
  logic                 rsp_valid;
  logic [CPU_WIDTH-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/cpu_test_port.sv
// rtl/cpu_test_port.sv - test-control responder: verdict latch, console FIFO, watchdog
// Console FIFO is built only when CPU_TEST_PORT_CONSOLE_EN is defined.
module cpu_test_port #(
  parameter int CPU_WIDTH  = 32,
  parameter int WDT_LIMIT  = 10000,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 a_reset,
  cpu_test_port_if.slave       bus,
  output logic                 test_done,
  output logic                 test_pass,
  output logic [30:0]          fail_code,
  output logic                 con_valid,
  output logic [7:0]           con_data,
  input  logic                 con_ready
);
  localparam int WW       = $clog2(WDT_LIMIT);
  localparam int WDT_LAST = WDT_LIMIT - 1;
  localparam logic [WW-1:0] WDT_END = WDT_LAST[WW-1:0];

  typedef enum logic [1:0] {IDLE, RESP, DONE} state_t;

  state_t               state, state_nxt;
  logic [1:0]           reg_sel;
  logic                 ready_ok, accept, con_stall;
  logic                 fifo_full, fifo_empty;
  logic                 wdt_fire, tohost_we, verdict_we, wdt_to;
  logic [WW-1:0]        wdt_cnt;
  logic [31:0]          cycles_q;
  logic [CPU_WIDTH-1:0] tohost_q, rdata_mux;
  logic                 unused_addr;

  assign reg_sel     = bus.req_addr[3:2];
  assign unused_addr = ^bus.req_addr[1:0];
  // A full FIFO only blocks console stores; other registers stay reachable.
  assign con_stall   = fifo_full && bus.req_we && (reg_sel == 2'd1);
  assign ready_ok    = (state != RESP) && !con_stall;
  assign accept      = bus.req_valid && ready_ok;
  assign bus.req_ready = ready_ok;
  assign bus.rsp_valid = (state == RESP);

  assign tohost_we  = accept && bus.req_we && (reg_sel == 2'd0) && !test_done;
  assign verdict_we = tohost_we && bus.req_wdata[0];
  assign wdt_fire   = !test_done && (wdt_cnt == WDT_END);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept)        state_nxt = RESP;
        else if (wdt_fire) state_nxt = DONE;
      end
      RESP:    state_nxt = (test_done || wdt_fire) ? DONE : IDLE;
      DONE:    if (accept) state_nxt = RESP;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rdata_mux = '0;
    unique case (reg_sel)
      2'd0: rdata_mux = tohost_q;
      2'd1: rdata_mux = '0;
      2'd2: rdata_mux = cycles_q;
      2'd3: rdata_mux = {27'b0, wdt_to, fifo_full, fifo_empty, test_pass, test_done};
      default: rdata_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge a_reset) begin
    if (a_reset) begin
      state         <= IDLE;
      bus.rsp_rdata <= '0;
      cycles_q      <= '0;
      wdt_cnt       <= '0;
      tohost_q      <= '0;
      test_done     <= 1'b0;
      test_pass     <= 1'b0;
      fail_code     <= '0;
      wdt_to        <= 1'b0;
    end else begin
      state         <= state_nxt;
      bus.rsp_rdata <= (accept && !bus.req_we) ? rdata_mux : '0;
      cycles_q      <= cycles_q + 32'd1;
      if (!test_done) wdt_cnt <= wdt_cnt + WW'(1);
      if (tohost_we)  tohost_q <= bus.req_wdata;
      // A firmware verdict landing on the expiry cycle takes precedence.
      if (verdict_we) begin
        test_done <= 1'b1;
        test_pass <= (bus.req_wdata == 1);
        fail_code <= (bus.req_wdata == 1) ? 31'd0 : bus.req_wdata[CPU_WIDTH-1:1];
      end else if (wdt_fire) begin
        test_done <= 1'b1;
        test_pass <= 1'b0;
        fail_code <= 31'h7FFF_FFFF;
        wdt_to    <= 1'b1;
      end
    end
  end

`ifdef CPU_TEST_PORT_CONSOLE_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = FIFO_DEPTH[AW:0];

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fifo_cnt;
  logic          push, pop;

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == FULL_CNT);
  assign push       = accept && bus.req_we && (reg_sel == 2'd1);
  assign pop        = con_valid && con_ready;
  assign con_valid  = !fifo_empty;
  assign con_data   = con_valid ? fifo_mem[rd_ptr] : 8'h00;

  always_ff @(posedge clk or posedge a_reset) begin
    if (a_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      fifo_cnt <= fifo_cnt + (AW+1)'(1);
      else if (pop && !push) fifo_cnt <= fifo_cnt - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.req_wdata[7:0];
  end
`else
  logic unused_console;
  assign unused_console = con_ready;
  assign fifo_empty     = 1'b1;
  assign fifo_full      = 1'b0;
  assign con_valid      = 1'b0;
  assign con_data       = 8'h00;
`endif
endmodule

// File: tb/tb_cpu_test_port.sv
// tb/tb_cpu_test_port.sv - directed scoreboard bench for cpu_test_port
// Console expectations follow CPU_TEST_PORT_CONSOLE_EN.
module tb_cpu_test_port;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cpu_test_port_if #(.CPU_WIDTH(32)) bus ();
  cpu_test_port_if #(.CPU_WIDTH(32)) wbus ();

  logic        done, pass, cv, cr;
  logic [30:0] fcode;
  logic [7:0]  cd;
  logic        wdone, wpass, wcv;
  logic [30:0] wfcode;
  logic [7:0]  wcd;

  cpu_test_port #(.CPU_WIDTH(32), .WDT_LIMIT(5000), .FIFO_DEPTH(8)) dut (
    .clk(clk), .a_reset(rst), .bus(bus),
    .test_done(done), .test_pass(pass), .fail_code(fcode),
    .con_valid(cv), .con_data(cd), .con_ready(cr)
  );

  cpu_test_port #(.CPU_WIDTH(32), .WDT_LIMIT(20), .FIFO_DEPTH(8)) wdut (
    .clk(clk), .a_reset(rst), .bus(wbus),
    .test_done(wdone), .test_pass(wpass), .fail_code(wfcode),
    .con_valid(wcv), .con_data(wcd), .con_ready(1'b0)
  );

  int          passed = 0;
  int          fails  = 0;
  int          total  = 0;
  logic [31:0] rsp_q[$];
  logic [7:0]  con_q[$];
  logic [31:0] cyc;
  logic [31:0] last_rd;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= '0;
    else     cyc <= cyc + 32'd1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit w, input logic v, input logic we, input logic [3:0] a,
                       input logic [31:0] d);
    if (w) begin
      wbus.req_valid = v; wbus.req_we = we; wbus.req_addr = a; wbus.req_wdata = d;
    end else begin
      bus.req_valid = v; bus.req_we = we; bus.req_addr = a; bus.req_wdata = d;
    end
  endtask

  function automatic logic rdy(input bit w);
    return w ? wbus.req_ready : bus.req_ready;
  endfunction

  // Issue one request at a negedge; returns at the negedge of the response cycle.
  task automatic bus_req(input bit w, input logic we, input logic [3:0] a, input logic [31:0] d,
                         input logic [31:0] exp, input bit exp_cyc);
    int n = 0;
    drive(w, 1'b1, we, a, d);
    while (!rdy(w) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_wait", {31'b0, n < 40}, 32'd1);
    rsp_q.push_back(exp_cyc ? cyc : exp);
    @(negedge clk);
    drive(w, 1'b0, 1'b0, 4'h0, 32'h0);
    last_rd = w ? wbus.rsp_rdata : bus.rsp_rdata;
    check("rsp_valid", {31'b0, w ? wbus.rsp_valid : bus.rsp_valid}, 32'd1);
    check("rsp_rdata", last_rd, rsp_q.pop_front());
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 4'h0, 32'h0);
    cr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] first;
    bit          acc, got9, seen;
    rst = 1'b1;
    cr  = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 4'h0, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    check("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
    check("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("rst_test_done", {31'b0, done}, 32'd0);
    check("rst_test_pass", {31'b0, pass}, 32'd0);
    check("rst_fail_code", {1'b0, fcode}, 32'd0);
    check("rst_con_valid", {31'b0, cv}, 32'd0);
    check("rst_con_data", {24'b0, cd}, 32'd0);

    bus_req(1'b0, 1'b0, 4'h8, 32'h0, 32'h0, 1'b1);
    first = last_rd;
    bus_req(1'b0, 1'b0, 4'h8, 32'h0, 32'h0, 1'b1);
    check("cycles_delta", last_rd - first, 32'd2);

    bus_req(1'b0, 1'b1, 4'h0, 32'h10, 32'h0, 1'b0);
    check("even_store_no_done", {31'b0, done}, 32'd0);
    bus_req(1'b0, 1'b0, 4'h0, 32'h0, 32'h10, 1'b0);
    bus_req(1'b0, 1'b0, 4'h4, 32'h0, 32'h0, 1'b0);
    bus_req(1'b0, 1'b0, 4'hC, 32'h0, 32'h4, 1'b0);

    bus_req(1'b0, 1'b1, 4'h0, 32'h1, 32'h0, 1'b0);
    check("pass_done", {31'b0, done}, 32'd1);
    check("pass_pass", {31'b0, pass}, 32'd1);
    check("pass_code", {1'b0, fcode}, 32'd0);
    @(negedge clk);
    check("rsp_one_cycle", {31'b0, bus.rsp_valid}, 32'd0);
    bus_req(1'b0, 1'b0, 4'hC, 32'h0, 32'h7, 1'b0);

    reset_dut();
    bus_req(1'b0, 1'b1, 4'h0, 32'h7, 32'h0, 1'b0);
    check("fail_done", {31'b0, done}, 32'd1);
    check("fail_pass", {31'b0, pass}, 32'd0);
    check("fail_code", {1'b0, fcode}, 32'd3);
    bus_req(1'b0, 1'b1, 4'h0, 32'h1, 32'h0, 1'b0);
    check("sticky_pass", {31'b0, pass}, 32'd0);
    check("sticky_code", {1'b0, fcode}, 32'd3);

    reset_dut();
    cr = 1'b1;
`ifdef CPU_TEST_PORT_CONSOLE_EN
    bus_req(1'b0, 1'b1, 4'h4, 32'h4F, 32'h0, 1'b0);
    check("con_o_valid", {31'b0, cv}, 32'd1);
    check("con_o_data", {24'b0, cd}, 32'h4F);
    bus_req(1'b0, 1'b1, 4'h4, 32'h4B, 32'h0, 1'b0);
    check("con_k_valid", {31'b0, cv}, 32'd1);
    check("con_k_data", {24'b0, cd}, 32'h4B);
    @(negedge clk);
    cr = 1'b0;
    check("con_drained", {31'b0, cv}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      con_q.push_back(8'hA0 + 8'(i));
      bus_req(1'b0, 1'b1, 4'h4, 32'hA0 + 32'(i), 32'h0, 1'b0);
    end
    bus_req(1'b0, 1'b0, 4'hC, 32'h0, 32'h8, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 4'h4, 32'hA8);
    repeat (3) @(negedge clk);
    check("full_stall_ready", {31'b0, bus.req_ready}, 32'd0);
    check("full_stall_rsp", {31'b0, bus.rsp_valid}, 32'd0);
    con_q.push_back(8'hA8);
    cr   = 1'b1;
    acc  = 1'b0;
    got9 = 1'b0;
    for (int k = 0; k < 40 && (con_q.size() != 0 || !got9); k++) begin
      if (acc) begin
        check("stalled_rsp", {31'b0, bus.rsp_valid}, 32'd1);
        drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
        got9 = 1'b1;
        acc  = 1'b0;
      end
      if (cv && cr) check("con_order", {24'b0, cd}, {24'b0, con_q.pop_front()});
      if (bus.req_valid && bus.req_ready) acc = 1'b1;
      @(negedge clk);
    end
    check("con_all_out", {31'b0, con_q.size() == 0 && got9}, 32'd1);
    check("con_empty_end", {31'b0, cv}, 32'd0);
`else
    bus_req(1'b0, 1'b1, 4'h4, 32'h4F, 32'h0, 1'b0);
    check("nocon_valid", {31'b0, cv}, 32'd0);
    check("nocon_data", {24'b0, cd}, 32'd0);
    cr = 1'b0;
    for (int i = 0; i < 9; i++) bus_req(1'b0, 1'b1, 4'h4, 32'hA0 + 32'(i), 32'h0, 1'b0);
    bus_req(1'b0, 1'b0, 4'hC, 32'h0, 32'h4, 1'b0);
`endif

    reset_dut();
    repeat (19) @(negedge clk);
    check("wdt_early", {31'b0, wdone}, 32'd0);
    @(negedge clk);
    check("wdt_done", {31'b0, wdone}, 32'd1);
    check("wdt_pass", {31'b0, wpass}, 32'd0);
    check("wdt_code", {1'b0, wfcode}, 32'h7FFF_FFFF);
    bus_req(1'b1, 1'b0, 4'hC, 32'h0, 32'h15, 1'b0);
    bus_req(1'b1, 1'b1, 4'h0, 32'h1, 32'h0, 1'b0);
    check("wdt_sticky", {31'b0, wpass}, 32'd0);

    reset_dut();
    drive(1'b0, 1'b1, 1'b0, 4'h8, 32'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
    check("mid_rsp_before", {31'b0, bus.rsp_valid}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rsp_async", {31'b0, bus.rsp_valid}, 32'd0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen |= bus.rsp_valid;
    end
    check("mid_no_rsp", {31'b0, seen}, 32'd0);
    check("mid_req_ready", {31'b0, bus.req_ready}, 32'd1);
    check("mid_rdata", bus.rsp_rdata, 32'd0);
    check("mid_done", {31'b0, done}, 32'd0);
    check("mid_pass", {31'b0, pass}, 32'd0);
    check("mid_code", {1'b0, fcode}, 32'd0);
    check("mid_con_valid", {31'b0, cv}, 32'd0);
    check("mid_con_data", {24'b0, cd}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
